// File: rtl/vpu_pkg.sv
// Shared types and sizing for the VPU writeback path.
// Holds the writeback state enum, the default geometry and the lane FIFO entry layout.
package vpu_pkg;

    localparam int WB_DATA_W        = 16;
    localparam int WB_ADDR_W        = 16;
    localparam int WB_B             = 4;
    localparam int WB_COLS_PER_LANE = 2;
    localparam int WB_TOTAL         = 2 * WB_B * WB_COLS_PER_LANE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_lane_fifo.sv
// Per-lane synchronous FIFO of {addr, data} entries.
// A push into a full FIFO is accepted only when the head is popped in the same cycle.
module wb_lane_fifo
    import vpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  logic      i_pop,
    input  wb_entry_t i_wdata,
    output wb_entry_t o_rdata,
    output logic      o_full,
    output logic      o_empty
);

    localparam int PW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [PW:0] r_wrPtr;
    logic [PW:0] r_rdPtr;
    wb_entry_t   r_mem [DEPTH];
    logic        w_doPush;
    logic        w_doPop;

    assign o_empty  = (r_wrPtr == r_rdPtr);
    assign o_full   = (r_wrPtr[PW] != r_rdPtr[PW]) && (r_wrPtr[PW-1:0] == r_rdPtr[PW-1:0]);
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);
    assign o_rdata  = r_mem[r_rdPtr[PW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr[PW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/vpu_writeback.sv
// Buffers the two VPU output lanes and arbitrates them onto the UB write port,
// generating column-major addresses and signalling done after the last accepted write.
module vpu_writeback
    import vpu_pkg::*;
#(
    parameter int DATA_W        = WB_DATA_W,
    parameter int ADDR_W        = WB_ADDR_W,
    parameter int B             = WB_B,
    parameter int COLS_PER_LANE = WB_COLS_PER_LANE,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DATA_W-1:0] lane_data_in_1,
    input  logic              lane_valid_in_1,
    input  logic [DATA_W-1:0] lane_data_in_2,
    input  logic              lane_valid_in_2,
    output logic              ub_wr_valid,
    input  logic              ub_wr_ready,
    output logic [ADDR_W-1:0] ub_wr_addr,
    output logic [DATA_W-1:0] ub_wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int TOTAL      = 2 * B * COLS_PER_LANE;
    localparam int LANE_TOTAL = B * COLS_PER_LANE;
    localparam int CNT_W      = $clog2(TOTAL + 1);

    wb_state_t         r_state;
    wb_state_t         w_nextState;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_accCnt;
    logic              r_ptr;
    logic              r_vld;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    logic              w_startRun;
    logic              w_handshake;
    logic              w_load;
    logic              w_grantAny;
    logic              w_grantLane;
    wb_entry_t         w_sel;
    logic [1:0]        w_laneValid;
    logic [1:0]        w_push;
    logic [1:0]        w_pop;
    logic [1:0]        w_full;
    logic [1:0]        w_empty;
    logic [1:0]        w_laneErr;
    logic [DATA_W-1:0] w_laneData [2];
    wb_entry_t         w_entryIn [2];
    wb_entry_t         w_head [2];

    assign w_startRun     = start && (r_state == IDLE);
    assign w_handshake    = r_vld && ub_wr_ready;
    assign w_laneValid    = {lane_valid_in_2, lane_valid_in_1};
    assign w_laneData[0]  = lane_data_in_1;
    assign w_laneData[1]  = lane_data_in_2;

    // Each lane owns its row/column/received counters and a FIFO; lane index gi picks the column parity.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic [CNT_W-1:0]  r_row;
        logic [CNT_W-1:0]  r_col;
        logic [CNT_W-1:0]  r_rcv;
        logic [ADDR_W-1:0] w_offset;
        logic              w_accept;

        assign w_accept  = (r_state == RUN) && w_laneValid[gi] && (r_rcv != CNT_W'(LANE_TOTAL));
        assign w_offset  = ADDR_W'(((32'(r_col) << 1) + 32'(gi)) * 32'(B) + 32'(r_row));
        assign w_push[gi] = w_accept;
        assign w_entryIn[gi].addr = WB_ADDR_W'(r_base + w_offset);
        assign w_entryIn[gi].data = WB_DATA_W'(w_laneData[gi]);
        assign w_laneErr[gi] = w_laneValid[gi] && (!w_accept || (w_full[gi] && !w_pop[gi]));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_row <= '0;
                r_col <= '0;
                r_rcv <= '0;
            end else if (w_startRun) begin
                r_row <= '0;
                r_col <= '0;
                r_rcv <= '0;
            end else if (w_accept) begin
                r_rcv <= r_rcv + CNT_W'(1);
                if (r_row == CNT_W'(B - 1)) begin
                    r_row <= '0;
                    r_col <= r_col + CNT_W'(1);
                end else begin
                    r_row <= r_row + CNT_W'(1);
                end
            end
        end

        wb_lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_push  (w_push[gi]),
            .i_pop   (w_pop[gi]),
            .i_wdata (w_entryIn[gi]),
            .o_rdata (w_head[gi]),
            .o_full  (w_full[gi]),
            .o_empty (w_empty[gi])
        );
    end

    // Round-robin only matters when both lanes have data; otherwise the lone lane wins.
    assign w_grantAny  = !w_empty[0] || !w_empty[1];
    assign w_grantLane = (!w_empty[0] && !w_empty[1]) ? r_ptr : w_empty[0];
    assign w_load      = !r_vld || ub_wr_ready;
    assign w_pop[0]    = w_load && w_grantAny && !w_grantLane;
    assign w_pop[1]    = w_load && w_grantAny && w_grantLane;
    assign w_sel       = w_grantLane ? w_head[1] : w_head[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_ptr  <= 1'b0;
        end else if (w_load) begin
            r_vld <= w_grantAny;
            if (w_grantAny) begin
                r_addr <= ADDR_W'(w_sel.addr);
                r_data <= DATA_W'(w_sel.data);
                r_ptr  <= ~w_grantLane;
            end
        end
    end

    assign ub_wr_valid = r_vld;
    assign ub_wr_addr  = r_addr;
    assign ub_wr_data  = r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_base   <= '0;
            r_accCnt <= '0;
            err      <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_startRun) begin
                r_base   <= base_addr;
                r_accCnt <= '0;
            end else if ((r_state == RUN) && w_handshake) begin
                r_accCnt <= r_accCnt + CNT_W'(1);
            end
            if (|w_laneErr)      err <= 1'b1;
            else if (w_startRun) err <= 1'b0;
        end
    end

    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: if (start) w_nextState = RUN;
            RUN: begin
                busy = 1'b1;
                if (w_handshake && (r_accCnt == CNT_W'(TOTAL - 1))) w_nextState = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vpu_writeback.sv
// Scoreboard bench for vpu_writeback: expected UB writes are queued as lane data is driven
// and compared in order as handshakes complete.
module tb_vpu_writeback;

    localparam int B      = 4;
    localparam int COLS   = 2;
    localparam int TOTAL  = 2 * B * COLS;
    localparam int LANE_N = B * COLS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] lane_data_in_1 = '0;
    logic        lane_valid_in_1 = 1'b0;
    logic [15:0] lane_data_in_2 = '0;
    logic        lane_valid_in_2 = 1'b0;
    logic        ub_wr_ready = 1'b1;
    logic        ub_wr_valid;
    logic [15:0] ub_wr_addr;
    logic [15:0] ub_wr_data;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t        expQ[$];
    int          checkCount = 0;
    int          failCount = 0;
    int          acceptCount = 0;
    int          donePulses = 0;
    int          donePhase = 0;
    bit          toggleReady = 1'b0;
    logic        prevStall = 1'b0;
    logic [15:0] prevAddr = '0;
    logic [15:0] prevData = '0;

    always #5 clk = ~clk;

    vpu_writeback #(
        .DATA_W        (16),
        .ADDR_W        (16),
        .B             (B),
        .COLS_PER_LANE (COLS),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .base_addr       (base_addr),
        .lane_data_in_1  (lane_data_in_1),
        .lane_valid_in_1 (lane_valid_in_1),
        .lane_data_in_2  (lane_data_in_2),
        .lane_valid_in_2 (lane_valid_in_2),
        .ub_wr_valid     (ub_wr_valid),
        .ub_wr_ready     (ub_wr_ready),
        .ub_wr_addr      (ub_wr_addr),
        .ub_wr_data      (ub_wr_data),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    // Every comparison in the bench funnels through here so the counters stay honest.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] laneAddr(input logic [15:0] base, input int lane, input int k);
        return base + 16'(((2 * (k / B) + lane) * B) + (k % B));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggleReady) ub_wr_ready = ~ub_wr_ready;
    endtask

    task automatic applyStimulus(input bit v1, input logic [15:0] d1, input bit v2, input logic [15:0] d2);
        lane_valid_in_1 = v1;
        lane_data_in_1  = d1;
        lane_valid_in_2 = v2;
        lane_data_in_2  = d2;
        tick();
        lane_valid_in_1 = 1'b0;
        lane_valid_in_2 = 1'b0;
    endtask

    // Monitor on the falling edge: scoreboard pops, stall stability and the done pulse shape.
    always @(negedge clk) begin
        if (rst) begin
            prevStall = 1'b0;
            donePhase = 0;
        end else begin
            if (start && !busy) acceptCount = 0;
            if (prevStall) begin
                checkOutput("stallValid", ub_wr_valid, 1);
                checkOutput("stallAddr", ub_wr_addr, prevAddr);
                checkOutput("stallData", ub_wr_data, prevData);
            end
            if (donePhase == 1) begin
                checkOutput("doneHigh", done, 1);
                checkOutput("busyLowInDone", busy, 0);
                donePhase = 2;
            end else if (donePhase == 2) begin
                checkOutput("doneSingleCycle", done, 0);
                donePhase = 0;
            end
            if (done) donePulses++;
            if (ub_wr_valid && ub_wr_ready) begin
                checkOutput("writeExpected", 32'(expQ.size() > 0), 1);
                if (expQ.size() > 0) begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("wrAddr", ub_wr_addr, e.addr);
                    checkOutput("wrData", ub_wr_data, e.data);
                end
                acceptCount++;
                if (acceptCount == TOTAL) donePhase = 1;
            end
            prevStall = ub_wr_valid && !ub_wr_ready;
            prevAddr  = ub_wr_addr;
            prevData  = ub_wr_data;
        end
    end

    task automatic doReset();
        toggleReady     = 1'b0;
        ub_wr_ready     = 1'b1;
        start           = 1'b0;
        lane_valid_in_1 = 1'b0;
        lane_valid_in_2 = 1'b0;
        rst             = 1'b1;
        expQ.delete();
        tick();
        tick();
        checkOutput("rstValid", ub_wr_valid, 0);
        checkOutput("rstAddr", ub_wr_addr, 0);
        checkOutput("rstData", ub_wr_data, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstErr", err, 0);
        rst = 1'b0;
        tick();
    endtask

    task automatic startRun(input logic [15:0] base);
        start     = 1'b1;
        base_addr = base;
        tick();
        start = 1'b0;
    endtask

    // Drive n elements on both lanes together, one beat every 'gap' cycles; stops early once stopAfter accepts are seen.
    task automatic streamBoth(input logic [15:0] base, input logic [15:0] d1, input logic [15:0] d2,
                              input int n, input int gap, input int stopAfter);
        for (int k = 0; k < n; k++) begin
            expQ.push_back('{addr: laneAddr(base, 0, k), data: d1 + 16'(k)});
            expQ.push_back('{addr: laneAddr(base, 1, k), data: d2 + 16'(k)});
            applyStimulus(1'b1, d1 + 16'(k), 1'b1, d2 + 16'(k));
            for (int g = 1; g < gap; g++) begin
                if (stopAfter > 0 && acceptCount >= stopAfter) return;
                tick();
            end
            if (stopAfter > 0 && acceptCount >= stopAfter) return;
        end
    endtask

    task automatic waitDrain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (expQ.size() == 0) break;
            tick();
        end
        checkOutput("drainComplete", 32'(expQ.size()), 0);
        repeat (3) tick();
    endtask

    initial begin
        int d0;

        // Simultaneous stream with ready held high.
        doReset();
        startRun(16'h0100);
        checkOutput("busyAfterStart", busy, 1);
        d0 = donePulses;
        streamBoth(16'h0100, 16'h0001, 16'h0011, LANE_N, 2, 0);
        waitDrain(200);
        checkOutput("s1DonePulses", 32'(donePulses - d0), 1);
        checkOutput("s1Err", err, 0);
        checkOutput("s1IdleBusy", busy, 0);
        checkOutput("s1Accepts", 32'(acceptCount), TOTAL);

        // Backpressure: four beats per lane pile up behind ready=0.
        doReset();
        ub_wr_ready = 1'b0;
        startRun(16'h0100);
        streamBoth(16'h0100, 16'h0021, 16'h0031, 4, 1, 0);
        repeat (4) tick();
        checkOutput("bpErr", err, 0);
        checkOutput("bpHeldValid", ub_wr_valid, 1);
        ub_wr_ready = 1'b1;
        waitDrain(200);
        checkOutput("bpErrAfter", err, 0);
        checkOutput("bpAccepts", 32'(acceptCount), 8);

        // Overflow: a lane 2 entry stalls in the output register, then lane 1 overfills its FIFO.
        doReset();
        ub_wr_ready = 1'b0;
        startRun(16'h0100);
        d0 = donePulses;
        expQ.push_back('{addr: laneAddr(16'h0100, 1, 0), data: 16'h0011});
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'h0011);
        for (int k = 0; k < 5; k++) begin
            if (k < 4) expQ.push_back('{addr: laneAddr(16'h0100, 0, k), data: 16'hAAA0 + 16'(k)});
            applyStimulus(1'b1, 16'hAAA0 + 16'(k), 1'b0, 16'h0000);
            if (k == 3) checkOutput("ovfErrBefore", err, 0);
            if (k == 4) checkOutput("ovfErrOn5th", err, 1);
        end
        tick();
        ub_wr_ready = 1'b1;
        waitDrain(100);
        repeat (5) tick();
        checkOutput("ovfNoDone", 32'(donePulses - d0), 0);
        checkOutput("ovfStillBusy", busy, 1);
        checkOutput("ovfErrSticky", err, 1);
        checkOutput("ovfAccepts", 32'(acceptCount), 5);

        // Stray valid while idle.
        doReset();
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'h7FFF);
        tick();
        checkOutput("strayErr", err, 1);
        checkOutput("strayNoWrite", ub_wr_valid, 0);
        tick();
        checkOutput("strayNoWriteLater", ub_wr_valid, 0);
        startRun(16'h0100);
        checkOutput("strayErrCleared", err, 0);

        // Reset mid-run, then a clean transfer at a new base.
        doReset();
        startRun(16'h0100);
        streamBoth(16'h0100, 16'h0001, 16'h0011, LANE_N, 2, 6);
        checkOutput("midAccepts", 32'(acceptCount >= 6), 1);
        rst = 1'b1;
        expQ.delete();
        tick();
        checkOutput("midRstValid", ub_wr_valid, 0);
        checkOutput("midRstAddr", ub_wr_addr, 0);
        checkOutput("midRstData", ub_wr_data, 0);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstDone", done, 0);
        checkOutput("midRstErr", err, 0);
        rst = 1'b0;
        tick();
        startRun(16'h0200);
        d0 = donePulses;
        streamBoth(16'h0200, 16'h0001, 16'h0011, LANE_N, 2, 0);
        waitDrain(200);
        checkOutput("midDonePulses", 32'(donePulses - d0), 1);
        checkOutput("midErr", err, 0);

        // Ready toggling every cycle over a slower-paced stream.
        doReset();
        startRun(16'h0100);
        toggleReady = 1'b1;
        d0 = donePulses;
        streamBoth(16'h0100, 16'h0001, 16'h0011, LANE_N, 4, 0);
        waitDrain(300);
        toggleReady = 1'b0;
        ub_wr_ready = 1'b1;
        tick();
        checkOutput("tglDonePulses", 32'(donePulses - d0), 1);
        checkOutput("tglErr", err, 0);
        checkOutput("tglAccepts", 32'(acceptCount), TOTAL);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
